// File: rtl/fifo_rd_stream_pkg.sv
// Shared limits and sizing helpers for the FIFO-read-to-stream adapter.
package fifo_rd_stream_pkg;

  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_RD_LATENCY = 2;
  localparam int BEAT_CNT_W     = 16;

  // Buffer must absorb every read still in the FIFO pipeline plus one beat of slack.
  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus output stream bundle; master is the adapter, slave the surroundings.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last,
    output busy
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last,
    input  busy
  );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Small circular word buffer: write at tail, pop at head, head word always visible.
module fifo_rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 2,
  localparam int PTR_W      = ptr_width(DEPTH),
  localparam int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_pop,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_valid;
  logic [CNT_W-1:0]      w_count_nxt;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    w_count_nxt = r_count;
    case ({i_wr, i_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      // NOTE: storage is cleared too, so the head word reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port with RD_LATENCY read delay into a valid/ready stream.
// Define FIFO_RD_STREAM_LAST_EN to build the per-line beat counter driving m_last.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 0,
  parameter int LINE_LEN   = 1024
) (
  input  logic               rd_clk,
  input  logic               rd_rst_n,
  fifo_rd_stream_if.master   bus
);

  localparam int DEPTH = buf_depth(RD_LATENCY);
  localparam int CNT_W = cnt_width(DEPTH);

  logic                  w_rd_en;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_valid;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_inflight;
  logic [CNT_W-1:0]      w_pending;
  logic [DATA_WIDTH-1:0] w_head;

  // Credit check uses only registered state, so m_ready never reaches fifo_rd_en.
  assign w_pending = w_count + w_inflight;
  assign w_rd_en   = ~bus.fifo_empty & (w_pending < CNT_W'(DEPTH)) & rd_rst_n;
  assign w_pop     = w_valid & bus.m_ready;

  if (RD_LATENCY == 0) begin : g_no_pipe
    assign w_wr       = w_rd_en;
    assign w_inflight = '0;
  end else begin : g_pipe
    logic [RD_LATENCY-1:0] r_rd_pipe;

    always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
        r_rd_pipe <= '0;
      end else begin
        r_rd_pipe[0] <= w_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end

    assign w_wr       = r_rd_pipe[RD_LATENCY-1];
    assign w_inflight = CNT_W'($countones(r_rd_pipe));
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .i_clk     (rd_clk),
    .i_rst_n   (rd_rst_n),
    .i_wr      (w_wr),
    .i_wr_data (bus.fifo_rd_data),
    .i_pop     (w_pop),
    .o_count   (w_count),
    .o_valid   (w_valid),
    .o_head    (w_head)
  );

`ifdef FIFO_RD_STREAM_LAST_EN
  logic [BEAT_CNT_W-1:0] r_beat;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == BEAT_CNT_W'(LINE_LEN - 1)) ? '0 : r_beat + BEAT_CNT_W'(1);
    end
  end

  assign bus.m_last = w_valid & (r_beat == BEAT_CNT_W'(LINE_LEN - 1));
`else
  assign bus.m_last = 1'b0;
`endif

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_data     = w_head;
  assign bus.m_valid    = w_valid;
  assign bus.busy       = (w_pending != '0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: three instances (RD_LATENCY 0,1,2) share stimulus and are
// checked every cycle against a queue model of words read but not yet delivered.
module tb_fifo_rd_stream;

  localparam int          DW      = 32;
  localparam int          LINE    = 4;
  localparam logic [31:0] GARBAGE = 32'hBAD0_0000;
`ifdef FIFO_RD_STREAM_LAST_EN
  localparam logic [11:0] LAST_PAT = 12'h888;
`else
  localparam logic [11:0] LAST_PAT = 12'h000;
`endif

  typedef struct {
    logic [31:0] data;
    int          avail;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic empty;
  logic ready;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  for (genvar L = 0; L <= 2; L++) begin : g
    localparam int D       = L + 2;
    localparam int OUT_IDX = (L == 0) ? 0 : L - 1;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(
      .DATA_WIDTH (DW),
      .RD_LATENCY (L),
      .LINE_LEN   (LINE)
    ) dut (
      .rd_clk   (clk),
      .rd_rst_n (rst_n),
      .bus      (bus)
    );

    assign bus.fifo_empty = empty;
    assign bus.m_ready    = ready;

    logic [31:0] rp = 0;
    logic [31:0] pipe [2];
    logic        rd_s;
    word_t       q[$];
    int          beats   = 0;
    int          n_beats = 0;

    // FIFO behaviour: word n is the n-th word read; returned data shows up L cycles later.
    initial begin
      pipe[0] = GARBAGE;
      pipe[1] = GARBAGE;
      bus.fifo_rd_data = (L == 0) ? rp : GARBAGE;
      forever begin
        @(negedge clk);
        rd_s = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        pipe[1] = pipe[0];
        pipe[0] = rd_s ? rp : GARBAGE;
        if (rd_s) rp++;
        bus.fifo_rd_data = (L == 0) ? rp : pipe[OUT_IDX];
      end
    end

    // Each read word is deliverable L+1 cycles after its read, in read order.
    always @(negedge clk) begin
      logic exp_valid;
      logic exp_last;
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      if (q.size() > 0) exp_valid = (q[0].avail <= cyc);
      check($sformatf("L%0d rd_en", L), bus.fifo_rd_en,
            rst_n && !empty && (q.size() < D));
      check($sformatf("L%0d rd_while_empty", L), bus.fifo_rd_en && empty, 0);
      check($sformatf("L%0d m_valid", L), bus.m_valid, exp_valid);
      check($sformatf("L%0d busy", L), bus.busy, q.size() != 0);
      if (exp_valid) begin
        check($sformatf("L%0d m_data", L), bus.m_data, q[0].data);
`ifdef FIFO_RD_STREAM_LAST_EN
        exp_last = ((beats % LINE) == LINE - 1);
`endif
        check($sformatf("L%0d m_last", L), bus.m_last, exp_last);
      end else begin
        check($sformatf("L%0d m_last_idle", L), bus.m_last, 0);
      end
      if (!rst_n) begin
        q.delete();
        beats = 0;
      end else begin
        if (exp_valid && ready) begin
          void'(q.pop_front());
          beats++;
          n_beats++;
        end
        if (bus.fifo_rd_en) q.push_back('{data: rp, avail: cyc + L + 1});
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_state(input string tag);
    check({tag, " L0 m_valid"}, g[0].bus.m_valid, 0);
    check({tag, " L1 m_valid"}, g[1].bus.m_valid, 0);
    check({tag, " L2 m_valid"}, g[2].bus.m_valid, 0);
    check({tag, " L0 busy"},    g[0].bus.busy,    0);
    check({tag, " L1 busy"},    g[1].bus.busy,    0);
    check({tag, " L2 busy"},    g[2].bus.busy,    0);
    check({tag, " L0 m_data"},  g[0].bus.m_data,  0);
    check({tag, " L1 m_data"},  g[1].bus.m_data,  0);
    check({tag, " L2 m_data"},  g[2].bus.m_data,  0);
    check({tag, " L0 m_last"},  g[0].bus.m_last,  0);
    check({tag, " L1 m_last"},  g[1].bus.m_last,  0);
    check({tag, " L2 m_last"},  g[2].bus.m_last,  0);
  endtask

  initial begin
    int          reads [3];
    int          k;
    int          base [3];
    int          prog;
    int          c;
    logic [11:0] last_pat;

    last_pat = LAST_PAT;
    rst_n = 1'b0;
    ready = 1'b0;
    empty = 1'b0;

    // Reset with a non-empty FIFO: no reads may be issued.
    repeat (3) begin
      @(negedge clk);
      check("rst L2 rd_en", g[2].bus.fifo_rd_en, 0);
    end
    idle_state("reset");
    drive_edge();
    rst_n = 1'b1;
    ready = 1'b1;

    // Latency 1, ready held: read at t0, valid from t0+2, words 0x00..0x0F back to back.
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j == 0) check("p1 L1 first rd_en", g[1].bus.fifo_rd_en, 1);
      check("p1 L1 m_valid", g[1].bus.m_valid, j >= 2);
      if (j >= 2) check("p1 L1 m_data", g[1].bus.m_data, j - 2);
      drive_edge();
      if (j == 17) empty = 1'b1;
    end

    repeat (10) begin
      @(negedge clk);
      drive_edge();
    end
    @(negedge clk);
    check("drain L0 busy", g[0].bus.busy, 0);
    check("drain L1 busy", g[1].bus.busy, 0);
    check("drain L2 busy", g[2].bus.busy, 0);
    drive_edge();
    ready = 1'b0;
    empty = 1'b0;

    // Downstream stalled: each instance reads exactly its buffer depth, then holds word 18.
    reads = '{0, 0, 0};
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (g[0].bus.fifo_rd_en) reads[0]++;
      if (g[1].bus.fifo_rd_en) reads[1]++;
      if (g[2].bus.fifo_rd_en) reads[2]++;
      if (g[2].bus.m_valid) check("p2 L2 held data", g[2].bus.m_data, 18);
      drive_edge();
      if (j == 11) ready = 1'b1;
    end
    check("p2 L0 reads", reads[0], 2);
    check("p2 L1 reads", reads[1], 3);
    check("p2 L2 reads", reads[2], 4);
    check("p2 L2 rd_en off", g[2].bus.fifo_rd_en, 0);

    // One pop frees a slot, the refill goes in flight, then a one-cycle reset hits.
    @(negedge clk);
    drive_edge();
    ready = 1'b0;
    @(negedge clk);
    check("p3 L2 refill rd_en", g[2].bus.fifo_rd_en, 1);
    drive_edge();
    rst_n = 1'b0;
    @(negedge clk);
    drive_edge();
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    idle_state("post_reset");
    drive_edge();

    // Stream restarts at word 23; line marks on beats 3, 7, 11 when enabled.
    k = 0;
    for (int j = 0; j < 40 && k < 12; j++) begin
      @(negedge clk);
      if (g[2].bus.m_valid) begin
        check("p3 L2 data", g[2].bus.m_data, 23 + k);
        check("p3 L2 last", g[2].bus.m_last, last_pat[k]);
        k++;
      end
      drive_edge();
    end
    check("p3 L2 beats", k, 12);

    // Random ready and empty until every instance has delivered 10000 words.
    base[0] = g[0].n_beats;
    base[1] = g[1].n_beats;
    base[2] = g[2].n_beats;
    prog = 0;
    c = 0;
    while (prog < 10000 && c < 60000) begin
      @(negedge clk);
      prog = g[0].n_beats - base[0];
      if (g[1].n_beats - base[1] < prog) prog = g[1].n_beats - base[1];
      if (g[2].n_beats - base[2] < prog) prog = g[2].n_beats - base[2];
      drive_edge();
      ready = 1'($urandom_range(0, 1));
      empty = ($urandom_range(0, 3) == 0);
      c++;
    end
    check("rand words delivered", prog >= 10000, 1);

    empty = 1'b1;
    ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      drive_edge();
    end
    @(negedge clk);
    check("final L0 busy",    g[0].bus.busy,    0);
    check("final L1 busy",    g[1].bus.busy,    0);
    check("final L2 busy",    g[2].bus.busy,    0);
    check("final L2 m_valid", g[2].bus.m_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of FIFO read data and stream data, range 1-256.
REQ-002 SHALL have parameter RD_LATENCY, default 0, cycles from fifo_rd_en asserted to the word being valid on fifo_rd_data, range 0-2.
REQ-003 SHALL have parameter LINE_LEN, default 1024, beats per line for m_last generation, range 2-65535.
REQ-004 rd_clk  in  1  single clock; all logic on its rising edge.
REQ-005 rd_rst_n  in  1  reset, synchronous, active-low.
REQ-006 fifo_rd_en  out  1  read strobe to the FIFO read port.
REQ-007 fifo_rd_data  in  DATA_WIDTH  FIFO read data.
REQ-008 fifo_empty  in  1  FIFO empty flag, 1 active.
REQ-009 m_data  out  DATA_WIDTH  stream data.
REQ-010 m_valid  out  1  stream valid.
REQ-011 m_ready  in  1  downstream ready.
REQ-012 m_last  out  1  last beat of a line.
REQ-013 busy  out  1  any word in flight or buffered.

Function
REQ-014 Internal buffer depth SHALL be D = RD_LATENCY+2 words, circular, with count register.
REQ-015 pending = in-flight reads + buffered words; SHALL always satisfy pending <= D.
REQ-016 fifo_rd_en SHALL equal ~fifo_empty & (pending < D) & rd_rst_n; no combinational path from m_ready.
REQ-017 fifo_rd_en SHALL never be 1 while fifo_empty is 1.
REQ-018 Word read at cycle t SHALL be sampled from fifo_rd_data at cycle t+RD_LATENCY and written into the buffer at that edge.
REQ-019 m_valid SHALL be registered, equal to (buffer count != 0); first m_valid at cycle t+RD_LATENCY+1 after first fifo_rd_en at t.
REQ-020 m_data SHALL be the buffer head word; m_data and m_last SHALL be stable while m_valid & ~m_ready.
REQ-021 Beat transfers on m_valid & m_ready; head pointer advances, count decrements.
REQ-022 Simultaneous buffer write and transfer in one cycle SHALL leave count unchanged.
REQ-023 With m_ready held 1 and FIFO never empty, SHALL sustain one beat per cycle.
REQ-024 Word order on m_data SHALL equal FIFO read order; no drop, no duplicate.
REQ-025 Buffer pointers SHALL wrap modulo D.
REQ-026 busy SHALL be 1 when pending != 0.

Reset
REQ-027 While rd_rst_n = 0 at an edge: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0, count=0, pointers=0, in-flight pipeline=0, line counter=0.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight words; returned data for reads issued before reset SHALL be ignored.
REQ-029 First fifo_rd_en after reset release SHALL be no earlier than the first edge with rd_rst_n = 1.

Configuration
REQ-030 Macro FIFO_RD_STREAM_LAST_EN defined: beat counter 0..LINE_LEN-1 increments per transfer, wraps to 0; m_last = 1 when head beat is at count LINE_LEN-1.
REQ-031 Macro FIFO_RD_STREAM_LAST_EN undefined: beat counter not built; m_last tied 0; all other behaviour identical.

Structure
REQ-032 Package fifo_rd_stream_pkg SHALL hold max DATA_WIDTH, max RD_LATENCY, depth function D and pointer width function clog2(D).
REQ-033 Buffer SHALL be sub-module fifo_rd_skid_buf (write, pop, count, head data); control and line counter in top.

Verification
REQ-034 RD_LATENCY=1, FIFO preloaded 0x00..0x0F, m_ready=1 -> fifo_rd_en at t0, m_valid from t0+2, m_data 0x00..0x0F on 16 consecutive cycles.
REQ-035 RD_LATENCY=2, m_ready=0 with FIFO non-empty -> exactly 4 reads issued, fifo_rd_en then 0, m_data=first word held stable.
REQ-036 Random m_ready (50%) and random fifo_empty, 10000 words -> output sequence equals input, fifo_rd_en never 1 with fifo_empty=1.
REQ-037 Macro defined, LINE_LEN=4, 12 beats -> m_last=1 on beats 3, 7, 11 only; macro undefined -> m_last always 0.
REQ-038 rd_rst_n=0 for 1 cycle with 3 words buffered and 1 in flight -> next cycle m_valid=0, busy=0; post-reset stream starts with next FIFO word.
